eric_clapton_core: RTL and testbench

ERIC_CLAPTON_CORE -- requirements
Module: eric_clapton_core

---
 rtl/eric_clapton_core.sv | 63 ++++++
 tb/tb_eric_clapton_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/eric_clapton_core.sv
// Two-stage pipeline: registers three 4-bit operands, mixes them with
// choose/majority/rotate-sum logic and registers the odd parity of the sum.
module eric_clapton_core (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] A_e,
   input  logic [3:0] B_e,
   input  logic [3:0] C_e,
   output logic       Yout
);

   logic [3:0] r_a;
   logic [3:0] r_b;
   logic [3:0] r_c;
   logic       r_yout;
   logic [3:0] w_ch;
   logic [3:0] w_maj;
   logic [3:0] w_s0;
   logic [3:0] w_t;

   function automatic logic [3:0] rotr4(input logic [3:0] v, input int unsigned n);
      logic [7:0] w;
      w = {v, v} >> n;
      return w[3:0];
   endfunction

   function automatic logic parity4(input logic [3:0] v);
      return ^v;
   endfunction

   // Stage 1: operand capture, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a <= 4'd0;
         r_b <= 4'd0;
         r_c <= 4'd0;
      end else begin
         r_a <= A_e;
         r_b <= B_e;
         r_c <= C_e;
      end
   end

   // Stage 2 combinational mix; the 4-bit sum drops carries so it wraps mod 16
   always_comb begin
      w_ch  = (r_a & r_b) | (~r_a & r_c);
      w_maj = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);
      w_s0  = rotr4(r_a, 32'd1) ^ rotr4(r_a, 32'd2) ^ rotr4(r_a, 32'd3);
      w_t   = w_ch + w_maj + w_s0 + r_c;
   end

   // Result register: odd parity of the stage-2 sum
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_yout <= 1'b0;
      end else begin
         r_yout <= parity4(w_t);
      end
   end

   assign Yout = r_yout;

endmodule

// File: tb/tb_eric_clapton_core.sv
// Directed and exhaustive self-checking bench for eric_clapton_core:
// reset behaviour, hand-computed vectors, full operand sweep, mid-stream reset.
module tb_eric_clapton_core;

   logic       clk;
   logic       reset;
   logic [3:0] A_e;
   logic [3:0] B_e;
   logic [3:0] C_e;
   logic       Yout;

   int n_checks;
   int n_errors;
   logic exp_q1;
   logic exp_q2;

   eric_clapton_core dut (
      .clk  (clk),
      .reset(reset),
      .A_e  (A_e),
      .B_e  (B_e),
      .C_e  (C_e),
      .Yout (Yout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic obs, input logic exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Independent bit-level reference of the stage-2 mix and parity
   function automatic logic ref_y(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      int sum;
      int ch;
      int maj;
      int s0;
      logic [3:0] t;
      ch = 0; maj = 0; s0 = 0;
      for (int i = 0; i < 4; i++) begin
         if (a[i] ? b[i] : c[i]) ch = ch + (1 << i);
         if ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2) maj = maj + (1 << i);
         if (a[(i + 1) % 4] ^ a[(i + 2) % 4] ^ a[(i + 3) % 4]) s0 = s0 + (1 << i);
      end
      sum = (ch + maj + s0 + int'(c)) % 16;
      t = sum[3:0];
      return t[0] ^ t[1] ^ t[2] ^ t[3];
   endfunction

   // Check the result due from two steps ago, then present a new triple
   task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic exp_bit);
      @(negedge clk);
      check_eq(tag, Yout, exp_q2);
      exp_q2 = exp_q1;
      exp_q1 = exp_bit;
      A_e = a; B_e = b; C_e = c;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_q1 = 1'b0;
      exp_q2 = 1'b0;
      A_e = 4'd15; B_e = 4'd15; C_e = 4'd15;
      reset = 1'b0;
      #1;
      check_eq("reset_imm", Yout, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         A_e = 4'($urandom_range(15)); B_e = 4'($urandom_range(15)); C_e = 4'($urandom_range(15));
         check_eq("reset_hold", Yout, 1'b0);
      end

      // Release together with the first directed vector
      @(negedge clk);
      reset = 1'b1;
      A_e = 4'd0; B_e = 4'd0; C_e = 4'd0;
      exp_q2 = 1'b0;
      exp_q1 = 1'b0;

      step("zero",      4'd1,  4'd0,  4'd0,  1'b1);
      step("a1",        4'd0,  4'd0,  4'd1,  1'b1);
      step("c1",        4'd15, 4'd15, 4'd15, 1'b0);
      step("all15",     4'd0,  4'd0,  4'd0,  1'b0);
      step("zero2",     4'd5,  4'd3,  4'd10, 1'b1);
      step("pre_5_3_10",4'd0,  4'd0,  4'd0,  1'b0);
      step("v_5_3_10",  4'd1,  4'd0,  4'd0,  1'b1);
      step("post_zero", 4'd1,  4'd0,  4'd0,  1'b1);
      step("a1_again",  4'd1,  4'd0,  4'd0,  1'b1);
      step("a1_hold",   4'd1,  4'd0,  4'd0,  1'b1);

      // Asynchronous assertion between edges while Yout is high
      @(posedge clk);
      #2;
      check_eq("pre_async", Yout, 1'b1);
      reset = 1'b0;
      #1;
      check_eq("async_assert", Yout, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         A_e = 4'd1; B_e = 4'd0; C_e = 4'd0;
         check_eq("async_hold", Yout, 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      A_e = 4'd0; B_e = 4'd0; C_e = 4'd1;
      exp_q2 = 1'b0;
      exp_q1 = 1'b1;
      step("rel_edge1", 4'd0, 4'd0, 4'd0, 1'b0);
      step("rel_edge2", 4'd0, 4'd0, 4'd0, 1'b0);

      // Exhaustive sweep, one triple per cycle
      for (int k = 0; k < 4096; k++) begin
         logic [11:0] v;
         v = 12'(k);
         step("sweep", v[11:8], v[7:4], v[3:0], ref_y(v[11:8], v[7:4], v[3:0]));
      end

      // Sweep with reset pulsed mid-stream
      for (int k = 0; k < 40; k++) begin
         logic [11:0] v;
         v = 12'(k * 97 + 5);
         step("sweep2_pre", v[11:8], v[7:4], v[3:0], ref_y(v[11:8], v[7:4], v[3:0]));
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("mid_reset_imm", Yout, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         A_e = 4'd15; B_e = 4'd15; C_e = 4'd14;
         check_eq("mid_reset_hold", Yout, 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      A_e = 4'd5; B_e = 4'd3; C_e = 4'd10;
      exp_q2 = 1'b0;
      exp_q1 = 1'b1;
      for (int k = 0; k < 40; k++) begin
         logic [11:0] v;
         v = 12'(k * 211 + 17);
         step("sweep2_post", v[11:8], v[7:4], v[3:0], ref_y(v[11:8], v[7:4], v[3:0]));
      end
      step("drain1", 4'd0, 4'd0, 4'd0, 1'b0);
      step("drain2", 4'd0, 4'd0, 4'd0, 1'b0);
      step("drain3", 4'd0, 4'd0, 4'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
